// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the system bus arbiter
package bus_arbiter_pkg;

  localparam int ARB_MAX_MASTERS       = 16;
  localparam int DEFAULT_GRANT_TIMEOUT = 16;
  localparam int DEFAULT_BUS_TIMEOUT   = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    ABORT   = 2'd3
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant and transaction handshake bundle of the system bus
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] granted;
  logic                   begin_transaction_in;
  logic                   end_transaction_in;
  logic                   error_in;
  logic                   end_transaction_out;

  // master: the requesting/bus side; slave: the arbiter
  modport master (
    output request, begin_transaction_in, end_transaction_in, error_in,
    input  granted, end_transaction_out
  );

  modport slave (
    input  request, begin_transaction_in, end_transaction_in, error_in,
    output granted, end_transaction_out
  );

endinterface

// File: rtl/bus_arbiter_rr_priority_picker.sv
// rtl/bus_arbiter_rr_priority_picker.sv - combinational round-robin pick of the first requester at or above pointer
module rr_priority_picker
  import bus_arbiter_pkg::*;
#(
  parameter int  NUM_MASTERS = 4,
  localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [IDX_W-1:0]       pointer,
  output logic [NUM_MASTERS-1:0] pick,
  output logic [IDX_W-1:0]       pick_index
);

  logic [2*NUM_MASTERS-1:0] doubled;
  logic [2*NUM_MASTERS-1:0] masked;
  logic                     found;

  assign doubled = {request, request};

  // Lower copy is masked below pointer; the upper copy supplies the wrap-around.
  always_comb begin
    masked     = '0;
    pick       = '0;
    pick_index = '0;
    found      = 1'b0;
    for (int i = 0; i < 2*NUM_MASTERS; i++) begin
      masked[i] = doubled[i] & ((i >= NUM_MASTERS) || (i >= int'(pointer)));
    end
    for (int i = 0; i < 2*NUM_MASTERS; i++) begin
      if (!found && masked[i]) begin
        found      = 1'b1;
        pick_index = IDX_W'(i % NUM_MASTERS);
      end
    end
    if (found) begin
      pick[pick_index] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin system bus arbiter with grant and bus watchdogs
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int  NUM_MASTERS   = 4,
  parameter int  GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT,
  parameter int  BUS_TIMEOUT   = DEFAULT_BUS_TIMEOUT,
  localparam int IDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic             system_clock,
  input  logic             system_reset,
  bus_arbiter_if.slave     bus,
  output logic [IDX_W-1:0] active_master,
  output logic             bus_idle,
  output logic             timeout_error
);

  localparam int CNT_W = $clog2(max_int(GRANT_TIMEOUT, BUS_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUS_LAST   = CNT_W'(BUS_TIMEOUT - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] granted_q, granted_d;
  logic [IDX_W-1:0]       active_q, active_d;
  logic [IDX_W-1:0]       pointer_q, pointer_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   end_out_q, end_out_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0] pick;
  logic [IDX_W-1:0]       pick_index;
  logic [IDX_W-1:0]       next_pointer;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .request    (bus.request),
    .pointer    (pointer_q),
    .pick       (pick),
    .pick_index (pick_index)
  );

  // The master that just finished drops to lowest priority.
  assign next_pointer = (active_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : active_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    granted_d = granted_q;
    active_d  = active_q;
    pointer_d = pointer_q;
    count_d   = (count_q == '1) ? count_q : count_q + 1'b1;
    end_out_d = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.request) begin
          granted_d = pick;
          active_d  = pick_index;
          count_d   = '0;
          state_d   = GRANTED;
        end
      end
      GRANTED: begin
        // begin outranks both the dropped request and the grant watchdog
        if (bus.begin_transaction_in) begin
          count_d = '0;
          state_d = BUSY;
        end else if (!bus.request[active_q]) begin
          granted_d = '0;
          pointer_d = next_pointer;
          state_d   = IDLE;
        end else if (count_q == GRANT_LAST) begin
          granted_d = '0;
          pointer_d = next_pointer;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (bus.end_transaction_in || bus.error_in) begin
          granted_d = '0;
          pointer_d = next_pointer;
          state_d   = IDLE;
        end else if (count_q == BUS_LAST) begin
          end_out_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = ABORT;
        end
      end
      ABORT: begin
        granted_d = '0;
        pointer_d = next_pointer;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q   <= IDLE;
      granted_q <= '0;
      active_q  <= '0;
      pointer_q <= '0;
      count_q   <= '0;
      end_out_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      granted_q <= granted_d;
      active_q  <= active_d;
      pointer_q <= pointer_d;
      count_q   <= count_d;
      end_out_q <= end_out_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.granted             = granted_q;
  assign bus.end_transaction_out = end_out_q;
  assign active_master           = active_q;
  assign timeout_error           = timeout_q;
  assign bus_idle                = (state_q == IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;

  localparam int N = 4;

  logic       system_clock;
  logic       system_reset;
  logic [1:0] active_master;
  logic       bus_idle;
  logic       timeout_error;
  logic [3:0] exp_g;
  int         checks   = 0;
  int         failures = 0;

  bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  bus_arbiter #(
    .NUM_MASTERS   (N),
    .GRANT_TIMEOUT (16),
    .BUS_TIMEOUT   (32)
  ) dut (
    .system_clock  (system_clock),
    .system_reset  (system_reset),
    .bus           (bus),
    .active_master (active_master),
    .bus_idle      (bus_idle),
    .timeout_error (timeout_error)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    system_reset             = 1'b1;
    bus.request              = '0;
    bus.begin_transaction_in = 1'b0;
    bus.end_transaction_in   = 1'b0;
    bus.error_in             = 1'b0;
    tick(2);
    chk("rst_granted", bus.granted, 0);
    chk("rst_active", active_master, 0);
    chk("rst_end_out", bus.end_transaction_out, 0);
    chk("rst_timeout", timeout_error, 0);
    chk("rst_idle", bus_idle, 1);
    system_reset = 1'b0;
    tick();

    // single requester
    bus.request = 4'b0100;
    tick();
    chk("single_grant", bus.granted, 4'b0100);
    chk("single_active", active_master, 2);
    chk("single_not_idle", bus_idle, 0);
    tick();
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    chk("single_busy_grant", bus.granted, 4'b0100);
    tick(4);
    bus.end_transaction_in = 1'b1;
    tick();
    bus.end_transaction_in = 1'b0;
    bus.request = 4'b0000;
    chk("single_release", bus.granted, 0);
    chk("single_idle", bus_idle, 1);
    chk("single_pointer", dut.pointer_q, 3);

    // begin while idle is ignored
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    chk("idle_begin_ignored", bus_idle, 1);

    // round robin from a fresh pointer
    system_reset = 1'b1;
    tick();
    system_reset = 1'b0;
    bus.request = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      chk("rr_grant", bus.granted, exp_g);
      chk("rr_active", active_master, k % 4);
      bus.begin_transaction_in = 1'b1;
      tick();
      bus.begin_transaction_in = 1'b0;
      tick();
      bus.end_transaction_in = 1'b1;
      tick();
      bus.end_transaction_in = 1'b0;
      chk("rr_gap", bus.granted, 0);
      tick();
    end
    // master 1 now granted; dropping its request revokes silently
    chk("rr_wrap_next", bus.granted, 4'b0010);
    bus.request = 4'b0000;
    tick();
    chk("drop_revoke", bus.granted, 0);
    chk("drop_no_timeout", timeout_error, 0);

    // grant timeout on master 1, master 2 waiting
    bus.request = 4'b0010;
    tick();
    chk("gto_grant", bus.granted, 4'b0010);
    bus.request = 4'b0110;
    tick(15);
    chk("gto_still_granted", bus.granted, 4'b0010);
    chk("gto_no_pulse_yet", timeout_error, 0);
    tick();
    chk("gto_revoked", bus.granted, 0);
    chk("gto_pulse", timeout_error, 1);
    tick();
    chk("gto_next_grant", bus.granted, 4'b0100);
    chk("gto_pulse_cleared", timeout_error, 0);

    // request drop together with begin enters BUSY
    bus.request = 4'b0010;
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    chk("drop_begin_busy", bus_idle, 0);
    chk("drop_begin_grant", bus.granted, 4'b0100);
    bus.request = 4'b0000;
    bus.error_in = 1'b1;
    tick();
    bus.error_in = 1'b0;
    chk("error_release", bus.granted, 0);

    // bus timeout on master 0
    bus.request = 4'b0001;
    tick();
    chk("bto_grant", bus.granted, 4'b0001);
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    tick(31);
    chk("bto_no_abort_yet", bus.end_transaction_out, 0);
    tick();
    chk("bto_end_out", bus.end_transaction_out, 1);
    chk("bto_pulse", timeout_error, 1);
    chk("bto_grant_held", bus.granted, 4'b0001);
    bus.request = 4'b0000;
    tick();
    chk("bto_released", bus.granted, 0);
    chk("bto_end_out_clear", bus.end_transaction_out, 0);
    chk("bto_idle", bus_idle, 1);

    // end on the timeout cycle wins
    bus.request = 4'b0001;
    tick();
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    tick(31);
    bus.end_transaction_in = 1'b1;
    tick();
    bus.end_transaction_in = 1'b0;
    bus.request = 4'b0000;
    chk("race_released", bus.granted, 0);
    chk("race_no_end_out", bus.end_transaction_out, 0);
    chk("race_no_pulse", timeout_error, 0);
    tick();

    // reset in the middle of a transaction on master 3
    bus.request = 4'b1000;
    tick();
    chk("rbusy_grant", bus.granted, 4'b1000);
    chk("rbusy_active", active_master, 3);
    bus.begin_transaction_in = 1'b1;
    tick();
    bus.begin_transaction_in = 1'b0;
    tick();
    system_reset = 1'b1;
    tick();
    system_reset = 1'b0;
    chk("rbusy_granted", bus.granted, 0);
    chk("rbusy_pointer", dut.pointer_q, 0);
    chk("rbusy_end_out", bus.end_transaction_out, 0);
    chk("rbusy_idle", bus_idle, 1);
    tick();
    chk("rbusy_regrant", bus.granted, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
